// File: rtl/vga_rect_plotter_if.sv
// Command and pixel-stream bundle between a command source and the
// rectangle plotter. The master issues commands and receives pixels.
interface vga_rect_plotter_if #(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7,
  parameter int COLOR_BITS = 3
);
  logic                  start;
  logic [1:0]            mode;
  logic [X_WIDTH-1:0]    x0;
  logic [Y_WIDTH-1:0]    y0;
  logic [X_WIDTH-1:0]    w;
  logic [Y_WIDTH-1:0]    h;
  logic [COLOR_BITS-1:0] color;
  logic                  busy;
  logic                  done;
  logic [X_WIDTH-1:0]    vga_x;
  logic [Y_WIDTH-1:0]    vga_y;
  logic [COLOR_BITS-1:0] vga_color;
  logic                  vga_plot;

  modport master (
    output start, mode, x0, y0, w, h, color,
    input  busy, done, vga_x, vga_y, vga_color, vga_plot
  );

  modport slave (
    input  start, mode, x0, y0, w, h, color,
    output busy, done, vga_x, vga_y, vga_color, vga_plot
  );
endinterface

// File: rtl/vga_rect_plotter.sv
// Rectangle plotter: turns a pixel / filled-rectangle / clear-screen command
// into a gap-free row-major stream of pixel writes for a VGA adapter.
// The output coordinate registers double as the scan counters.
module vga_rect_plotter #(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7,
  parameter int COLOR_BITS = 3,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119
) (
  input  logic              clock,
  input  logic              reset,
  vga_rect_plotter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  // Limits at the widened (no-wrap) width and at the coordinate width.
  localparam logic [X_WIDTH:0]   XMAX_E = (X_WIDTH+1)'(X_MAX);
  localparam logic [Y_WIDTH:0]   YMAX_E = (Y_WIDTH+1)'(Y_MAX);
  localparam logic [X_WIDTH-1:0] XMAX_N = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] YMAX_N = Y_WIDTH'(Y_MAX);
  localparam logic [X_WIDTH:0]   X_ONE_E = (X_WIDTH+1)'(1);
  localparam logic [Y_WIDTH:0]   Y_ONE_E = (Y_WIDTH+1)'(1);
  localparam logic [X_WIDTH-1:0] X_INC = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_INC = Y_WIDTH'(1);

  state_t                state_q, state_d;
  logic [X_WIDTH-1:0]    xs_q, xs_d;     // row start column
  logic [X_WIDTH-1:0]    xe_q, xe_d;     // clipped row end column
  logic [Y_WIDTH-1:0]    ye_q, ye_d;     // clipped last row
  logic [X_WIDTH-1:0]    x_q, x_d;       // current pixel column (= vga_x)
  logic [Y_WIDTH-1:0]    y_q, y_d;       // current pixel row (= vga_y)
  logic [COLOR_BITS-1:0] col_q, col_d;
  logic                  plot_q, plot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [X_WIDTH:0]      x_sum;
  logic [Y_WIDTH:0]      y_sum;
  logic                  x_over, y_over;
  logic [X_WIDTH-1:0]    cmd_xs, cmd_xe;
  logic [Y_WIDTH-1:0]    cmd_ys, cmd_ye;
  logic                  cmd_empty;

  // Decode the live command into a clipped region; only used when accepted.
  always_comb begin
    x_sum  = {1'b0, bus.x0} + {1'b0, bus.w} - X_ONE_E;
    y_sum  = {1'b0, bus.y0} + {1'b0, bus.h} - Y_ONE_E;
    x_over = {1'b0, bus.x0} > XMAX_E;
    y_over = {1'b0, bus.y0} > YMAX_E;
    cmd_xs = bus.x0;
    cmd_ys = bus.y0;
    cmd_xe = bus.x0;
    cmd_ye = bus.y0;
    cmd_empty = x_over | y_over;
    case (bus.mode)
      2'b10: begin
        cmd_xs    = '0;
        cmd_ys    = '0;
        cmd_xe    = XMAX_N;
        cmd_ye    = YMAX_N;
        cmd_empty = 1'b0;
      end
      2'b01: begin
        // w/h of zero underflow x_sum/y_sum, but the command is empty then.
        cmd_xe    = (x_sum > XMAX_E) ? XMAX_N : x_sum[X_WIDTH-1:0];
        cmd_ye    = (y_sum > YMAX_E) ? YMAX_N : y_sum[Y_WIDTH-1:0];
        cmd_empty = x_over | y_over | (bus.w == '0) | (bus.h == '0);
      end
      default: ;
    endcase
  end

  // Next state and next outputs; coordinates/colour hold unless plotting.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cmd_empty) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // First pixel goes out on the cycle right after acceptance.
            state_d = S_DRAW;
            xs_d    = cmd_xs;
            xe_d    = cmd_xe;
            ye_d    = cmd_ye;
            x_d     = cmd_xs;
            y_d     = cmd_ys;
            col_d   = bus.color;
            plot_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (x_q == xe_q && y_q == ye_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          plot_d = 1'b1;
          busy_d = 1'b1;
          if (x_q == xe_q) begin
            x_d = xs_q;
            y_d = y_q + Y_INC;
          end else begin
            x_d = x_q + X_INC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything, including the command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vga_x     = x_q;
  assign bus.vga_y     = y_q;
  assign bus.vga_color = col_q;
  assign bus.vga_plot  = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Bench for vga_rect_plotter: table of directed commands, random commands
// against a region-scan reference model, and reset corner sequences.
module tb_vga_rect_plotter;
  localparam int XW = 8, YW = 7, CB = 3, XM = 159, YM = 119;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vga_rect_plotter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_BITS(CB)) bus ();

  vga_rect_plotter #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_BITS(CB),
                     .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]    mode;
    int            x0, y0, w, h, color;
    int            exp_n;
  } vec_t;

  typedef struct { int x, y, c; } px_t;

  int  n_chk = 0;
  int  n_fail = 0;
  px_t exp_q[$];
  px_t last_px = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: enumerate the clipped region with plain loops.
  function automatic void build_model(input vec_t c);
    int xs, xe, ys, ye;
    px_t p;
    exp_q.delete();
    if (c.mode == 2'b10) begin
      xs = 0; ys = 0; xe = XM; ye = YM;
    end else begin
      if (c.x0 > XM || c.y0 > YM) return;
      xs = c.x0; ys = c.y0;
      if (c.mode == 2'b01) begin
        if (c.w == 0 || c.h == 0) return;
        xe = (c.x0 + c.w - 1 > XM) ? XM : c.x0 + c.w - 1;
        ye = (c.y0 + c.h - 1 > YM) ? YM : c.y0 + c.h - 1;
      end else begin
        xe = xs; ye = ys;
      end
    end
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++) begin
        p.x = x; p.y = y; p.c = c.color;
        exp_q.push_back(p);
      end
  endfunction

  task automatic scramble_inputs();
    bus.mode  = 2'($urandom_range(0, 3));
    bus.x0    = XW'($urandom);
    bus.y0    = YW'($urandom);
    bus.w     = XW'($urandom);
    bus.h     = YW'($urandom);
    bus.color = CB'($urandom);
  endtask

  // Issue one command and follow it to its done pulse, checking every cycle.
  task automatic run_cmd(input vec_t c, output int nplot);
    int  p_n, cyc;
    bit  got_done;
    px_t e;
    build_model(c);
    p_n = exp_q.size();
    @(negedge clock);
    bus.mode  = c.mode;
    bus.x0    = XW'(c.x0);
    bus.y0    = YW'(c.y0);
    bus.w     = XW'(c.w);
    bus.h     = YW'(c.h);
    bus.color = CB'(c.color);
    bus.start = 1'b1;
    cyc = 0; nplot = 0; got_done = 0;
    while (!got_done && cyc < p_n + 5) begin
      @(negedge clock);
      cyc++;
      if (bus.vga_plot) begin
        chk("plot_slot", cyc, nplot + 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pix_x", bus.vga_x, e.x);
          chk("pix_y", bus.vga_y, e.y);
          chk("pix_c", bus.vga_color, e.c);
          last_px = e;
        end else
          chk("extra_plot", 1, 0);
        nplot++;
      end
      chk("busy_eq_plot", bus.busy, bus.vga_plot);
      if (bus.done) begin
        got_done = 1;
        chk("done_cycle", cyc, p_n + 1);
      end
      // Inputs change and start toggles while the command runs; both ignored.
      scramble_inputs();
      bus.start = (cyc <= p_n) ? 1'($urandom) : 1'b0;
    end
    chk("done_seen", got_done, 1);
    chk("plot_count", nplot, p_n);
    @(negedge clock);
    chk("idle_done", bus.done, 0);
    chk("idle_plot", bus.vga_plot, 0);
    chk("idle_busy", bus.busy, 0);
    chk("hold_x", bus.vga_x, last_px.x);
    chk("hold_y", bus.vga_y, last_px.y);
    chk("hold_c", bus.vga_color, last_px.c);
  endtask

  vec_t tbl[$];
  vec_t c;
  int   np;

  initial begin
    bus.start = 1'b0;
    bus.mode = '0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0; bus.color = '0;
    repeat (3) @(negedge clock);
    chk("rst_x", bus.vga_x, 0);
    chk("rst_y", bus.vga_y, 0);
    chk("rst_c", bus.vga_color, 0);
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;

    //           mode   x0   y0   w    h   col exp_n
    tbl.push_back('{2'b00,   5,   7,   0,   0, 5,   1});
    tbl.push_back('{2'b01,  10,  20,   3,   2, 2,   6});
    tbl.push_back('{2'b01, 158, 118,   4,   4, 7,   4});
    tbl.push_back('{2'b01,  30,  40,   0,   5, 3,   0});
    tbl.push_back('{2'b00, 200,  10,   0,   0, 1,   0});
    tbl.push_back('{2'b11,  12,  34,   9,   9, 6,   1});
    tbl.push_back('{2'b00,  50, 120,   0,   0, 4,   0});
    tbl.push_back('{2'b01, 159, 119,   1,   1, 3,   1});
    tbl.push_back('{2'b01, 150, 110, 255, 127, 5, 100});
    tbl.push_back('{2'b01,  20,  20,   4,   0, 2,   0});
    for (int i = 0; i < tbl.size(); i++) begin
      run_cmd(tbl[i], np);
      chk("tbl_count", np, tbl[i].exp_n);
    end

    // Random commands, biased toward the right/bottom edges for clipping.
    for (int i = 0; i < 40; i++) begin
      c.mode  = 2'($urandom_range(0, 3));
      if (c.mode == 2'b10) c.mode = 2'b01;
      c.x0    = $urandom_range(0, 175);
      c.y0    = $urandom_range(0, 127);
      c.w     = $urandom_range(0, 12);
      c.h     = $urandom_range(0, 8);
      c.color = $urandom_range(0, 7);
      c.exp_n = 0;
      run_cmd(c, np);
    end

    // Full clear screen with random start pulses during the fill.
    c = '{2'b10, 77, 88, 9, 9, 0, 19200};
    run_cmd(c, np);
    chk("clear_count", np, 19200);

    // Reset in the middle of a fill: everything zero, no done afterwards.
    @(negedge clock);
    bus.mode = 2'b10; bus.color = 3'b110; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (48) @(negedge clock);
    chk("fill_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_x", bus.vga_x, 0);
    chk("abort_y", bus.vga_y, 0);
    chk("abort_c", bus.vga_color, 0);
    chk("abort_plot", bus.vga_plot, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_no_done", bus.done, 0);
      chk("abort_no_plot", bus.vga_plot, 0);
    end
    last_px = '{0, 0, 0};
    c = '{2'b00, 33, 44, 0, 0, 7, 1};
    run_cmd(c, np);
    chk("post_abort_count", np, 1);

    // start together with reset must be dropped.
    @(negedge clock);
    bus.mode = 2'b00; bus.x0 = 8'd3; bus.y0 = 7'd4; bus.color = 3'd5;
    bus.start = 1'b1; reset = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; reset = 1'b0;
    chk("rst_start_plot", bus.vga_plot, 0);
    @(negedge clock);
    chk("rst_start_busy", bus.busy, 0);
    chk("rst_start_done", bus.done, 0);
    chk("rst_start_plot2", bus.vga_plot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
